// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: fetch PC, memory request FSM and
// a small instruction queue feeding the decoder.
module pc_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int              QDEPTH   = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Redirect_Valid,
    input  logic [XLEN-1:0] Redirect_PC,
    output logic            Mem_Req,
    output logic [XLEN-1:0] Mem_Addr,
    input  logic            Mem_Ack,
    input  logic [XLEN-1:0] Mem_Data,
    output logic            Instr_Valid,
    output logic [XLEN-1:0] Instr_Out,
    output logic [XLEN-1:0] Instr_PC,
    input  logic            Instr_Ready,
    output logic [XLEN-1:0] PC_Out
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]   FULL   = CW'(QDEPTH);
    localparam logic [CW-1:0]   ALMOST = CW'(QDEPTH - 1);
    localparam logic [XLEN-1:0] STEP   = XLEN'(4);
    localparam logic [PW-1:0]   ONE    = PW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            req_q;
    logic            req_n;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            push;
    logic            pop;

    logic [XLEN-1:0] q_data [QDEPTH];
    logic [XLEN-1:0] q_pc   [QDEPTH];

    // Outputs decode purely from registered state.
    assign Mem_Req     = req_q;
    assign Mem_Addr    = pc;
    assign PC_Out      = pc;
    assign Instr_Valid = (count != '0);
    assign Instr_Out   = Instr_Valid ? q_data[rd_ptr] : '0;
    assign Instr_PC    = Instr_Valid ? q_pc[rd_ptr] : '0;

    // Queue events and next FSM state; redirect outranks everything.
    always_comb begin
        pop     = Instr_Valid && Instr_Ready && !Redirect_Valid;
        push    = req_q && Mem_Ack && !Redirect_Valid
                  && ((count != FULL) || pop);
        state_n = state;
        if (Redirect_Valid) begin
            state_n = REQ;
        end else begin
            case (state)
                IDLE:    state_n = REQ;
                REQ: begin
                    if (push && !pop && (count == ALMOST))
                        state_n = STALL;
                end
                STALL: begin
                    if (count < FULL)
                        state_n = REQ;
                end
                default: state_n = IDLE;
            endcase
        end
        // The request line stays low for one cycle when entering REQ
        // from IDLE or via a redirect so the address settles first.
        req_n = (state_n == REQ) && (state != IDLE) && !Redirect_Valid;
    end

    // FSM, fetch PC, request flag and queue pointers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_n;
            req_q <= req_n;
            if (Redirect_Valid) begin
                pc     <= {Redirect_PC[XLEN-1:2], 2'b00};
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    pc     <= pc + STEP;
                    wr_ptr <= wr_ptr + ONE;
                end
                if (pop)
                    rd_ptr <= rd_ptr + ONE;
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue storage; contents are masked at the output while empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_data[wr_ptr] <= Mem_Data;
            q_pc[wr_ptr]   <= pc;
        end
    end

endmodule
